// File: rtl/mmc_spi_card_responder.sv
// Card-side SPI-mode MMC/SD responder: oversamples host SCLK/CS_N/MOSI and answers the CMD0/CMD1/CMD55/ACMD41 init flow with R1.
// Optional CRC7 checking of command frames is enabled by defining MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN.
//
// state       | meaning
// S_WAIT_INIT | counting power-up SCLK edges with CS_N high
// S_IDLE      | hunting for a command start byte (01xxxxxx)
// S_CMD       | collecting 4 argument bytes, then the CRC byte
// S_NCR       | sending 0xFF filler bytes ahead of the response
// S_RESP      | R1 queued for the next byte boundary, then shifting out

module mmc_spi_card_responder #(
  parameter int P_INIT_CLOCKS = 74,
  parameter int P_NCR         = 1,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic        iMMC_CLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iSPI_SCLK,
  input  logic        iSPI_CS_N,
  input  logic        iSPI_MOSI,
  output logic        oSPI_MISO,
  output logic        oINIT_DONE,
  output logic        oSPI_MODE,
  output logic        oIDLE,
  output logic        oCMD_VALID,
  output logic [5:0]  oCMD_INDEX,
  output logic [31:0] oCMD_ARG
);

  localparam int INIT_W = $clog2(P_INIT_CLOCKS + 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(P_INIT_CLOCKS);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [3:0]        NCR_LOAD  = 4'(P_NCR);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_CMD       = 3'd2;
  localparam logic [2:0] S_NCR       = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [P_SYNC_STAGES-1:0] sclkSync;
  logic [P_SYNC_STAGES-1:0] csSync;
  logic [P_SYNC_STAGES-1:0] mosiSync;
  logic                     sclkDly;
  logic                     sclkS;
  logic                     csHigh;
  logic                     mosiS;
  logic                     sclkRise;
  logic                     sclkFall;
  logic                     byteDone;

  logic [2:0]        state;
  logic [INIT_W-1:0] initLeft;
  logic [2:0]        bitCnt;
  logic [6:0]        rxReg;
  logic [7:0]        rxNext;
  logic [7:0]        txReg;
  logic [2:0]        argCnt;
  logic [3:0]        ncrLeft;
  logic [7:0]        r1Reg;
  logic              r1Loaded;
  logic              appFlag;
  logic [5:0]        idxLatch;
  logic [31:0]       argShift;

  logic       isCmd0;
  logic       isCmd1;
  logic       isCmd16;
  logic       isCmd55;
  logic       isAcmd41;
  logic       legal;
  logic       idleAfter;
  logic       crcOk;
  logic [7:0] r1Good;
  logic [7:0] r1CrcErr;

  assign sclkS    = sclkSync[P_SYNC_STAGES-1];
  assign csHigh   = csSync[P_SYNC_STAGES-1];
  assign mosiS    = mosiSync[P_SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkDly;
  assign sclkFall = ~sclkS & sclkDly;
  assign rxNext   = {rxReg, mosiS};
  assign byteDone = sclkRise & ~csHigh & (bitCnt == 3'd7);

  assign oSPI_MISO = csHigh ? 1'b1 : txReg[7];

`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
  logic [6:0] crcAcc;

  function automatic logic [6:0] crc7Byte(input logic [6:0] crcIn, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crcIn;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crcOk = (crcAcc == rxNext[7:1]);
`else
  assign crcOk = 1'b1;
`endif

  // Frame-end decode: legality and the idle flag the command leaves behind.
  always_comb begin
    isCmd0    = (idxLatch == 6'd0);
    isCmd1    = (idxLatch == 6'd1);
    isCmd16   = (idxLatch == 6'd16);
    isCmd55   = (idxLatch == 6'd55);
    isAcmd41  = (idxLatch == 6'd41) & appFlag;
    legal     = isCmd0 | isCmd1 | isCmd16 | isCmd55 | isAcmd41;
    idleAfter = oIDLE;
    if (isCmd0) begin
      idleAfter = 1'b1;
    end else if (isCmd1 | isAcmd41) begin
      idleAfter = 1'b0;
    end
    r1Good   = {4'b0000, 1'b0, ~legal, 1'b0, idleAfter};
    r1CrcErr = {4'b0000, 1'b1, 2'b00, oIDLE};
  end

  always_ff @(posedge iMMC_CLOCK) begin
    if (iRESET_SYNC) begin
      sclkSync   <= '0;
      csSync     <= '1;
      mosiSync   <= '1;
      sclkDly    <= 1'b0;
      state      <= S_WAIT_INIT;
      initLeft   <= INIT_LOAD;
      bitCnt     <= 3'd0;
      rxReg      <= 7'd0;
      txReg      <= 8'hFF;
      argCnt     <= 3'd0;
      ncrLeft    <= 4'd0;
      r1Reg      <= 8'hFF;
      r1Loaded   <= 1'b0;
      appFlag    <= 1'b0;
      idxLatch   <= 6'd0;
      argShift   <= 32'd0;
      oINIT_DONE <= 1'b0;
      oSPI_MODE  <= 1'b0;
      oIDLE      <= 1'b1;
      oCMD_VALID <= 1'b0;
      oCMD_INDEX <= 6'd0;
      oCMD_ARG   <= 32'd0;
`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
      crcAcc     <= 7'd0;
`endif
    end else begin
      sclkSync   <= {sclkSync[P_SYNC_STAGES-2:0], iSPI_SCLK};
      csSync     <= {csSync[P_SYNC_STAGES-2:0], iSPI_CS_N};
      mosiSync   <= {mosiSync[P_SYNC_STAGES-2:0], iSPI_MOSI};
      sclkDly    <= sclkS;
      oCMD_VALID <= 1'b0;

      // Shift datapath: sample on rising SCLK, update MISO on falling SCLK.
      if (csHigh) begin
        bitCnt <= 3'd0;
        txReg  <= 8'hFF;
      end else begin
        if (sclkRise) begin
          rxReg  <= rxNext[6:0];
          bitCnt <= bitCnt + 3'd1;
        end
        if (sclkFall) begin
          if (bitCnt == 3'd0) begin
            if ((state == S_RESP) && !r1Loaded) begin
              txReg    <= r1Reg;
              r1Loaded <= 1'b1;
            end else begin
              txReg <= 8'hFF;
            end
          end else begin
            txReg <= {txReg[6:0], 1'b1};
          end
        end
      end

      case (state)
        S_WAIT_INIT: begin
          if (sclkRise && csHigh) begin
            if (initLeft <= INIT_ONE) begin
              oINIT_DONE <= 1'b1;
              state      <= S_IDLE;
            end else begin
              initLeft <= initLeft - 1'b1;
            end
          end
        end

        S_IDLE: begin
          if (byteDone && (rxNext[7:6] == 2'b01)) begin
            idxLatch <= rxNext[5:0];
            argCnt   <= 3'd0;
            state    <= S_CMD;
`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
            crcAcc   <= crc7Byte(7'd0, rxNext);
`endif
          end
        end

        S_CMD: begin
          if (csHigh) begin
            state <= S_IDLE;
          end else if (byteDone) begin
            if (argCnt != 3'd4) begin
              argShift <= {argShift[23:0], rxNext};
              argCnt   <= argCnt + 3'd1;
`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
              crcAcc   <= crc7Byte(crcAcc, rxNext);
`endif
            end else if (!oSPI_MODE && (!isCmd0 || !crcOk)) begin
              state <= S_IDLE;
            end else if (!crcOk) begin
              r1Reg   <= r1CrcErr;
              ncrLeft <= NCR_LOAD;
              state   <= S_NCR;
            end else begin
              oCMD_VALID <= 1'b1;
              oCMD_INDEX <= idxLatch;
              oCMD_ARG   <= argShift;
              oIDLE      <= idleAfter;
              appFlag    <= isCmd55;
              if (isCmd0) oSPI_MODE <= 1'b1;
              r1Reg   <= r1Good;
              ncrLeft <= NCR_LOAD;
              state   <= S_NCR;
            end
          end
        end

        S_NCR: begin
          if (csHigh) begin
            state <= S_IDLE;
          end else if (byteDone) begin
            if (ncrLeft <= 4'd1) begin
              state <= S_RESP;
            end else begin
              ncrLeft <= ncrLeft - 4'd1;
            end
          end
        end

        S_RESP: begin
          if (csHigh || (byteDone && r1Loaded)) begin
            r1Loaded <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          r1Loaded <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_spi_card_responder.sv
// Randomized bench for mmc_spi_card_responder: a host-side SPI driver plus a command-level card model,
// with a per-cycle flag/register compare and per-byte MISO checks.
`timescale 1ns/1ps

module tb_mmc_spi_card_responder;

  localparam int NCR     = 2;
  localparam int SYNC    = 2;
  localparam int INITCLK = 74;
  localparam int HALF    = 5;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b0;
  logic        csN  = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        initDone;
  logic        spiMode;
  logic        idle;
  logic        cmdValid;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;

  int          nChecks   = 0;
  int          nFail     = 0;
  int          strobeCnt = 0;
  int          csHighCnt = 0;
  int          cycShown  = 0;
  logic        chkFlags  = 1'b0;
  logic [5:0]  capIdx    = 6'd0;
  logic [31:0] capArg    = 32'd0;

  logic        mInitDone = 1'b0;
  logic        mSpiMode  = 1'b0;
  logic        mIdle     = 1'b1;
  logic        mApp      = 1'b0;
  logic [5:0]  mIndex    = 6'd0;
  logic [31:0] mArg      = 32'd0;

  mmc_spi_card_responder #(
    .P_INIT_CLOCKS(INITCLK),
    .P_NCR(NCR),
    .P_SYNC_STAGES(SYNC)
  ) dut (
    .iMMC_CLOCK(clk),
    .iRESET_SYNC(rst),
    .iSPI_SCLK(sclk),
    .iSPI_CS_N(csN),
    .iSPI_MOSI(mosi),
    .oSPI_MISO(miso),
    .oINIT_DONE(initDone),
    .oSPI_MODE(spiMode),
    .oIDLE(idle),
    .oCMD_VALID(cmdValid),
    .oCMD_INDEX(cmdIndex),
    .oCMD_ARG(cmdArg)
  );

  always #10 clk = ~clk;

  // CRC7 as polynomial long division of the 40-bit message by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectReset();
    check("reset miso", 32'(miso), 32'd1);
    check("reset init_done", 32'(initDone), 32'd0);
    check("reset spi_mode", 32'(spiMode), 32'd0);
    check("reset idle", 32'(idle), 32'd1);
    check("reset cmd_valid", 32'(cmdValid), 32'd0);
    check("reset cmd_index", 32'(cmdIndex), 32'd0);
    check("reset cmd_arg", cmdArg, 32'd0);
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic initEdges(input int n);
    repeat (n) begin
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  // crcMode: 0 good CRC, 1 one CRC bit flipped, 2 CRC byte forced to 0x00.
  // abortAfter: 0 = full frame plus NCR fillers plus R1, else CS_N rises after that many bytes.
  task automatic doFrame(input logic [5:0] idx, input logic [31:0] arg, input int crcMode,
                         input int abortAfter, input bit pinEn, input logic [7:0] pinR1);
    logic [7:0] fb [6];
    logic [7:0] got;
    logic [7:0] expB;
    logic [7:0] r1;
    int         total;
    int         nSend;
    int         strobe0;
    bit         complete;
    bit         crcOk;
    bit         accepted;
    bit         resp;
    bit         legal;
    logic       nSpi;
    logic       nIdle;
    logic       nApp;

    fb[0] = {2'b01, idx};
    fb[1] = arg[31:24];
    fb[2] = arg[23:16];
    fb[3] = arg[15:8];
    fb[4] = arg[7:0];
    fb[5] = {crc7({fb[0], fb[1], fb[2], fb[3], fb[4]}), 1'b1};
    if (crcMode == 1) fb[5] = fb[5] ^ 8'h80;
    if (crcMode == 2) fb[5] = 8'h00;

    total    = 6 + NCR + 1;
    nSend    = (abortAfter == 0) ? total : abortAfter;
    complete = (nSend >= 6);

    crcOk = 1'b1;
`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
    crcOk = (fb[5][7:1] == crc7({fb[0], fb[1], fb[2], fb[3], fb[4]}));
`endif

    accepted = 1'b0;
    resp     = 1'b0;
    r1       = 8'hFF;
    nSpi     = mSpiMode;
    nIdle    = mIdle;
    nApp     = mApp;
    if (mInitDone && (mSpiMode || (idx == 6'd0 && crcOk))) begin
      resp = 1'b1;
      if (!crcOk) begin
        r1 = 8'h08 | {7'b0, mIdle};
      end else begin
        accepted = 1'b1;
        legal = (idx == 6'd0) || (idx == 6'd1) || (idx == 6'd16) || (idx == 6'd55) ||
                (idx == 6'd41 && mApp);
        if (idx == 6'd0) begin
          nSpi  = 1'b1;
          nIdle = 1'b1;
        end
        if (idx == 6'd1 || (idx == 6'd41 && mApp)) nIdle = 1'b0;
        nApp = (idx == 6'd55);
        r1   = {5'b00000, ~legal, 1'b0, nIdle};
      end
    end

    strobe0 = strobeCnt;
    csN = 1'b0;
    tick(HALF);
    for (int k = 0; k < nSend; k++) begin
      if (k == 5) chkFlags = 1'b0;
      spiByte((k < 6) ? fb[k] : 8'hFF, got);
      if (k == 5) begin
        if (accepted) begin
          mSpiMode = nSpi;
          mIdle    = nIdle;
          mApp     = nApp;
          mIndex   = idx;
          mArg     = arg;
        end
        chkFlags = 1'b1;
      end
      expB = (resp && k == 6 + NCR) ? r1 : 8'hFF;
      check($sformatf("miso byte %0d of cmd%0d", k, idx), 32'(got), 32'(expB));
      if (pinEn && k == 6 + NCR) check($sformatf("r1 literal cmd%0d", idx), 32'(got), 32'(pinR1));
    end
    tick(HALF);
    csN = 1'b1;
    tick(8);
    check($sformatf("strobe count cmd%0d", idx), 32'(strobeCnt - strobe0),
          32'((complete && accepted) ? 1 : 0));
    if (complete && accepted) begin
      check("strobe index", 32'(capIdx), 32'(idx));
      check("strobe arg", capArg, arg);
    end
  endtask

  initial begin
    logic [5:0]  rIdx;
    logic [31:0] rArg;
    logic [7:0]  dummy;
    int          rCrc;
    int          rAbort;

    fork
      begin
        forever begin
          @(negedge clk);
          if (csN) csHighCnt++;
          else csHighCnt = 0;
          if (cmdValid === 1'b1) begin
            strobeCnt++;
            capIdx = cmdIndex;
            capArg = cmdArg;
          end
          if (chkFlags) begin
            nChecks++;
            if (({initDone, spiMode, idle, cmdIndex, cmdArg} !==
                 {mInitDone, mSpiMode, mIdle, mIndex, mArg}) ||
                (csHighCnt >= 6 && miso !== 1'b1)) begin
              nFail++;
              if (cycShown < 10) begin
                cycShown++;
                $display("FAIL cycle compare: got init=%b mode=%b idle=%b idx=%0d arg=0x%0h miso=%b, expected init=%b mode=%b idle=%b idx=%0d arg=0x%0h (t=%0t)",
                         initDone, spiMode, idle, cmdIndex, cmdArg, miso,
                         mInitDone, mSpiMode, mIdle, mIndex, mArg, $time);
              end
            end
          end
        end
      end
    join_none

    tick(4);
    expectReset();
    rst = 1'b0;
    tick(2);
    chkFlags = 1'b1;

    check("crc7 of cmd0", 32'({crc7(40'h4000000000), 1'b1}), 32'h95);
    check("crc7 of cmd8", 32'({crc7(40'h48000001AA), 1'b1}), 32'h87);

    // Edges with CS_N low during power-up must not count toward the init clocks.
    doFrame(6'd0, 32'd0, 0, 0, 1'b0, 8'h00);
    initEdges(INITCLK - 1);
    tick(6);
    check("init_done after 73 edges", 32'(initDone), 32'd0);
    chkFlags = 1'b0;
    initEdges(1);
    tick(6);
    check("init_done after 74 edges", 32'(initDone), 32'd1);
    mInitDone = 1'b1;
    chkFlags  = 1'b1;

    doFrame(6'd1, 32'd0, 0, 0, 1'b0, 8'h00);
    check("spi_mode before cmd0", 32'(spiMode), 32'd0);
    doFrame(6'd0, 32'd0, 0, 0, 1'b1, 8'h01);
    check("spi_mode after cmd0", 32'(spiMode), 32'd1);
    check("index after cmd0", 32'(cmdIndex), 32'd0);
    doFrame(6'd8, 32'h000001AA, 0, 0, 1'b1, 8'h05);
    doFrame(6'd41, 32'h40000000, 0, 0, 1'b1, 8'h05);
    doFrame(6'd55, 32'd0, 0, 0, 1'b1, 8'h01);
    doFrame(6'd41, 32'h40000000, 0, 0, 1'b1, 8'h00);
    check("idle after acmd41", 32'(idle), 32'd0);
    check("arg after acmd41", cmdArg, 32'h40000000);
    doFrame(6'd41, 32'h40000000, 0, 0, 1'b1, 8'h04);
    doFrame(6'd16, 32'd512, 0, 0, 1'b1, 8'h00);
    doFrame(6'd0, 32'd0, 0, 0, 1'b1, 8'h01);
    doFrame(6'd1, 32'd0, 0, 4, 1'b0, 8'h00);
    check("idle after aborted cmd1", 32'(idle), 32'd1);
    doFrame(6'd1, 32'd0, 0, 0, 1'b1, 8'h00);
`ifdef MMC_SPI_CARD_RESPONDER_CRC_CHECK_EN
    doFrame(6'd0, 32'd0, 0, 0, 1'b1, 8'h01);
    doFrame(6'd1, 32'd0, 2, 0, 1'b1, 8'h09);
    check("idle after bad-crc cmd1", 32'(idle), 32'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       rIdx = 6'd0;
        1:       rIdx = 6'd1;
        2:       rIdx = 6'd8;
        3:       rIdx = 6'd16;
        4, 5:    rIdx = 6'd41;
        6, 7:    rIdx = 6'd55;
        8:       rIdx = 6'd17;
        default: rIdx = 6'($urandom_range(0, 63));
      endcase
      rArg   = $urandom;
      rCrc   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      rAbort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6 + NCR)) : 0;
      doFrame(rIdx, rArg, rCrc, rAbort, 1'b0, 8'h00);
    end

    // Reset in the middle of a frame wins over everything.
    csN = 1'b0;
    tick(HALF);
    spiByte(8'h41, dummy);
    spiByte(8'h00, dummy);
    chkFlags = 1'b0;
    mosi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    tick(2);
    rst  = 1'b1;
    sclk = 1'b0;
    csN  = 1'b1;
    tick(4);
    expectReset();
    rst = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
